alu_operand_issue: RTL and testbench
====================================

Name: alu_operand_issue

Overview:
- Upstream operand stage for the 32-bit ALU (op codes 0 AND, 1 OR, 2 SUB, 3 MUL, 4 DIV, 5 ADD, 6 SLT, 7 NOP).
- Holds the architectural register file and accepts decoded instructions (rs, rt, rd, op) over a valid/ready handshake.
- Reads operands with writeback bypass, tracks pending destinations with a scoreboard, and presents a, b, op2 to the ALU through a registered 2-entry skid buffer.
- Consumes the ALU result on the writeback port.

Parameters:
DATA_W, 32, operand/register width (ALU a, b, s)
ADDR_W, 5, register index width; 2**ADDR_W registers
OP_W, 3, ALU op code width (op2)

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  synchronous active-low reset
in_valid  in  1  upstream instruction valid
in_ready  out  1  stage can accept this cycle
in_rs  in  ADDR_W  source register for a
in_rt  in  ADDR_W  source register for b
in_rd  in  ADDR_W  destination register
in_op  in  OP_W  ALU op code, passed through unchanged
out_valid  out  1  operand bundle valid to ALU
out_ready  in  1  ALU/downstream consumes bundle
out_a  out  DATA_W  operand a
out_b  out  DATA_W  operand b
out_op2  out  OP_W  op code for ALU
out_rd  out  ADDR_W  destination carried with bundle
wb_en  in  1  writeback strobe
wb_addr  in  ADDR_W  writeback register
wb_data  in  DATA_W  writeback value (ALU s)

Behaviour:
- Interface: one clock, clk; reset rst_n is synchronous and active-low.
- Reset, sampled at a clk edge while rst_n=0:
  - All registers cleared to 0.
  - All scoreboard pending bits cleared.
  - Both buffer entries invalidated: out_valid=0, out_a=out_b=0, out_op2=0, out_rd=0.
  - Reset mid-operation drops any held bundles without a handshake; a wb_en in the reset cycle is ignored.
- Register 0:
  - Reads as 0.
  - Writes to it are ignored.
  - Never marked pending.
- Writeback: when wb_en=1 and wb_addr!=0, the register is written at the edge and its pending bit is cleared.
- Operand read occurs in the accept cycle (accept = in_valid & in_ready):
  - a = (wb_en && wb_addr==in_rs && in_rs!=0) ? wb_data : reg[in_rs].
  - b is formed likewise from in_rt.
  - Operands are a snapshot taken at accept and are not updated afterwards.
- Hazard:
  - hazard = (pending[in_rs] && !(wb_en && wb_addr==in_rs)) || the same term for in_rt.
  - in_ready = !hazard && !skid_full.
  - in_ready may depend combinationally on in_rs/in_rt and wb_*; it does not depend on out_ready.
- Scoreboard: on accept with in_rd!=0, pending[in_rd] is set. If wb clears the same index in the same cycle, the set wins.
- Latency: an accepted bundle appears on out_* at the next edge when the buffer is empty. Steady-state throughput is 1/cycle with out_ready=1.
- Buffer FSM (main = output register, skid = overflow entry):
  - EMPTY, on accept: go to FULL.
  - FULL, accept & out_ready: stay FULL; main takes the new bundle.
  - FULL, accept & !out_ready: go to SKID; skid takes the new bundle.
  - FULL, !accept & out_ready: go to EMPTY.
  - SKID: in_ready=0. On out_ready, skid moves to main and the state goes to FULL.
- Handshake rules:
  - out_* is held stable while out_valid=1 and out_ready=0.
  - out_valid=1 in FULL and SKID.
  - Bundles leave in acceptance order.
- Widths: no arithmetic is performed; fields pass through bit-exact. op code 4 with b=0 gets no special handling here.

Test Plan:
- Reset: drive rst_n=0 for 2 edges with in_valid=1 and wb_en=1 -> out_valid=0, in_ready=1 afterwards, reading r5 yields 0.
- Write r3=0x0000_00A5 and r4=0x0000_0010 via wb, then issue rs=3, rt=4, rd=6, op=5 with out_ready=1 -> next edge shows out_a=0xA5, out_b=0x10, out_op2=5, out_rd=6, out_valid=1.
- Bypass and register 0:
  - Issue rs=7 in the same cycle as wb_en, wb_addr=7, wb_data=0xDEAD_BEEF -> out_a=0xDEADBEEF.
  - Write wb r0=0x1234, then issue rs=0 -> out_a=0.
- Hazard:
  - Issue rd=8, then next cycle an instruction with rs=8 -> in_ready=0 until wb_en with wb_addr=8. In that wb cycle in_ready=1 and out_a=wb_data.
  - An instruction with rt=9, where r9 is not pending, is not stalled.
- Backpressure: hold out_ready=0 and offer 3 back-to-back instructions -> 2 accepted, in_ready=0 on the third, out_* stable. Release out_ready -> bundles emerge in order, one per cycle.
- Reset mid-operation: with the buffer in SKID and r8 pending, assert rst_n=0 for one edge -> out_valid=0, pending cleared, and an instruction with rs=8 is accepted immediately.

Source files
------------

// File: rtl/alu_operand_issue.sv
// Operand issue stage ahead of the ALU: register file with writeback bypass,
// pending-destination scoreboard and a registered two-entry output skid buffer.
module alu_operand_issue #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int OP_W   = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [ADDR_W-1:0] in_rs,
   input  logic [ADDR_W-1:0] in_rt,
   input  logic [ADDR_W-1:0] in_rd,
   input  logic [OP_W-1:0]   in_op,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_a,
   output logic [DATA_W-1:0] out_b,
   output logic [OP_W-1:0]   out_op2,
   output logic [ADDR_W-1:0] out_rd,
   input  logic              wb_en,
   input  logic [ADDR_W-1:0] wb_addr,
   input  logic [DATA_W-1:0] wb_data
);

   localparam int NREG = 2**ADDR_W;

   // Handshake: a transfer happens on an edge where valid and ready are both 1;
   // valid never waits on ready, and held bundles stay stable until taken.
   typedef enum logic [1:0] {EMPTY = 2'd0, FULL = 2'd1, SKID = 2'd2} state_t;

   state_t state, state_next;

   logic [DATA_W-1:0] regs [NREG];
   logic [NREG-1:0]   pending;

   logic [DATA_W-1:0] skid_a, skid_b;
   logic [OP_W-1:0]   skid_op;
   logic [ADDR_W-1:0] skid_rd;

   logic              wb_write;
   logic              hazard_rs, hazard_rt;
   logic              accept;
   logic [DATA_W-1:0] rd_a, rd_b;
   logic              load_main_new, load_main_skid, load_skid;

   assign wb_write  = wb_en && (wb_addr != '0);
   assign hazard_rs = pending[in_rs] && !(wb_en && wb_addr == in_rs);
   assign hazard_rt = pending[in_rt] && !(wb_en && wb_addr == in_rt);
   assign in_ready  = !(hazard_rs || hazard_rt) && (state != SKID);
   assign accept    = in_valid && in_ready;
   assign out_valid = (state != EMPTY);

   // Register 0 is never written, so the array read already returns 0 for it.
   assign rd_a = (wb_en && wb_addr == in_rs && in_rs != '0) ? wb_data : regs[in_rs];
   assign rd_b = (wb_en && wb_addr == in_rt && in_rt != '0) ? wb_data : regs[in_rt];

   always_ff @(posedge clk) begin
      if (!rst_n) state <= EMPTY;
      else        state <= state_next;
   end

   always_comb begin
      state_next     = state;
      load_main_new  = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
      case (state)
         EMPTY: begin
            if (accept) begin
               load_main_new = 1'b1;
               state_next    = FULL;
            end
         end
         FULL: begin
            if (accept && out_ready) begin
               load_main_new = 1'b1;
            end else if (accept) begin
               load_skid  = 1'b1;
               state_next = SKID;
            end else if (out_ready) begin
               state_next = EMPTY;
            end
         end
         SKID: begin
            if (out_ready) begin
               load_main_skid = 1'b1;
               state_next     = FULL;
            end
         end
         default: state_next = EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_a   <= '0;
         out_b   <= '0;
         out_op2 <= '0;
         out_rd  <= '0;
         skid_a  <= '0;
         skid_b  <= '0;
         skid_op <= '0;
         skid_rd <= '0;
      end else begin
         if (load_main_new) begin
            out_a   <= rd_a;
            out_b   <= rd_b;
            out_op2 <= in_op;
            out_rd  <= in_rd;
         end else if (load_main_skid) begin
            out_a   <= skid_a;
            out_b   <= skid_b;
            out_op2 <= skid_op;
            out_rd  <= skid_rd;
         end
         if (load_skid) begin
            skid_a  <= rd_a;
            skid_b  <= rd_b;
            skid_op <= in_op;
            skid_rd <= in_rd;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         regs    <= '{default: '0};
         pending <= '0;
      end else begin
         if (wb_write) begin
            regs[wb_addr]    <= wb_data;
            pending[wb_addr] <= 1'b0;
         end
         // Issued later in the same cycle, so a new reservation beats the clear.
         if (accept && in_rd != '0) pending[in_rd] <= 1'b1;
      end
   end

endmodule

// File: tb/tb_alu_operand_issue.sv
// Directed bench for alu_operand_issue with hand-computed expected values.
module tb_alu_operand_issue;

   logic        clk;
   logic        rst_n;
   logic        in_valid, in_ready;
   logic [4:0]  in_rs, in_rt, in_rd;
   logic [2:0]  in_op;
   logic        out_valid, out_ready;
   logic [31:0] out_a, out_b;
   logic [2:0]  out_op2;
   logic [4:0]  out_rd;
   logic        wb_en;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;

   int checks = 0;
   int errors = 0;
   logic [4:0] exp_q[$];

   alu_operand_issue dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_op(in_op),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_a(out_a), .out_b(out_b), .out_op2(out_op2), .out_rd(out_rd),
      .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [2:0] op);
      in_valid = 1'b1;
      in_rs    = rs;
      in_rt    = rt;
      in_rd    = rd;
      in_op    = op;
   endtask

   task automatic idle();
      in_valid = 1'b0;
      wb_en    = 1'b0;
   endtask

   task automatic wb(input logic [4:0] addr, input logic [31:0] data);
      wb_en   = 1'b1;
      wb_addr = addr;
      wb_data = data;
   endtask

   initial begin
      // Reset with activity on every input
      rst_n = 1'b0; out_ready = 1'b1;
      issue(5'd5, 5'd5, 5'd5, 3'd1);
      wb(5'd5, 32'hFFFF_FFFF);
      tick(); tick();
      rst_n = 1'b1;
      idle();
      #1;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_a", out_a, 32'd0);
      check("rst_out_rd", 32'(out_rd), 32'd0);
      issue(5'd5, 5'd5, 5'd0, 3'd7);
      tick(); idle();
      check("rst_r5_a", out_a, 32'd0);
      check("rst_r5_b", out_b, 32'd0);

      // Basic issue after writebacks
      wb(5'd3, 32'h0000_00A5); tick();
      wb(5'd4, 32'h0000_0010); tick();
      idle();
      issue(5'd3, 5'd4, 5'd6, 3'd5);
      #1 check("basic_in_ready", 32'(in_ready), 32'd1);
      tick(); idle();
      check("basic_valid", 32'(out_valid), 32'd1);
      check("basic_a", out_a, 32'h0000_00A5);
      check("basic_b", out_b, 32'h0000_0010);
      check("basic_op2", 32'(out_op2), 32'd5);
      check("basic_rd", 32'(out_rd), 32'd6);

      // Writeback bypass in the accept cycle
      issue(5'd7, 5'd0, 5'd0, 3'd1);
      wb(5'd7, 32'hDEAD_BEEF);
      tick(); idle();
      check("bypass_a", out_a, 32'hDEAD_BEEF);
      check("bypass_b_r0", out_b, 32'd0);

      // Register 0 ignores writes
      wb(5'd0, 32'h0000_1234); tick(); idle();
      issue(5'd0, 5'd7, 5'd0, 3'd0);
      tick(); idle();
      check("r0_a", out_a, 32'd0);
      check("r7_kept_b", out_b, 32'hDEAD_BEEF);

      // RAW hazard on r8, released by its writeback
      issue(5'd1, 5'd2, 5'd8, 3'd0);
      tick();
      issue(5'd8, 5'd0, 5'd10, 3'd2);
      #1 check("haz_stall0", 32'(in_ready), 32'd0);
      tick();
      check("haz_stall1", 32'(in_ready), 32'd0);
      check("haz_drained", 32'(out_valid), 32'd0);
      wb(5'd8, 32'h0000_55AA);
      #1 check("haz_wb_ready", 32'(in_ready), 32'd1);
      tick(); idle();
      check("haz_a", out_a, 32'h0000_55AA);
      check("haz_rd", 32'(out_rd), 32'd10);

      // Non-pending rt is not stalled
      issue(5'd0, 5'd9, 5'd0, 3'd6);
      #1 check("nohaz_ready", 32'(in_ready), 32'd1);
      tick(); idle();
      check("nohaz_valid", 32'(out_valid), 32'd1);
      check("nohaz_op2", 32'(out_op2), 32'd6);
      tick();
      check("nohaz_empty", 32'(out_valid), 32'd0);

      // Backpressure: two accepted, third stalls, outputs hold
      out_ready = 1'b0;
      issue(5'd3, 5'd4, 5'd11, 3'd3); exp_q.push_back(5'd11);
      #1 check("bp_ready_a", 32'(in_ready), 32'd1);
      tick();
      issue(5'd4, 5'd3, 5'd12, 3'd4); exp_q.push_back(5'd12);
      #1 check("bp_ready_b", 32'(in_ready), 32'd1);
      tick();
      issue(5'd7, 5'd0, 5'd13, 3'd6); exp_q.push_back(5'd13);
      #1 check("bp_ready_c", 32'(in_ready), 32'd0);
      for (int i = 0; i < 2; i++) begin
         tick();
         check("bp_hold_valid", 32'(out_valid), 32'd1);
         check("bp_hold_a", out_a, 32'h0000_00A5);
         check("bp_hold_rd", 32'(out_rd), 32'd11);
         check("bp_hold_ready", 32'(in_ready), 32'd0);
      end
      void'(exp_q.pop_front());
      out_ready = 1'b1;
      tick();
      check("bp_order_b", 32'(out_rd), 32'(exp_q.pop_front()));
      check("bp_b_a", out_a, 32'h0000_0010);
      check("bp_b_b", out_b, 32'h0000_00A5);
      check("bp_c_ready", 32'(in_ready), 32'd1);
      tick(); idle();
      check("bp_order_c", 32'(out_rd), 32'(exp_q.pop_front()));
      check("bp_c_a", out_a, 32'hDEAD_BEEF);
      check("bp_c_op2", 32'(out_op2), 32'd6);
      tick();
      check("bp_empty", 32'(out_valid), 32'd0);

      // Same-cycle reserve and writeback of r15: reservation persists
      issue(5'd0, 5'd0, 5'd15, 3'd0);
      wb(5'd15, 32'h0000_0007);
      tick(); wb_en = 1'b0;
      issue(5'd15, 5'd0, 5'd0, 3'd0);
      #1 check("setwins_stall", 32'(in_ready), 32'd0);
      idle();
      tick();

      // Reset while in SKID with r8 pending
      out_ready = 1'b0;
      issue(5'd0, 5'd0, 5'd8, 3'd0); tick();
      issue(5'd0, 5'd0, 5'd14, 3'd1); tick();
      idle();
      #1 check("pre_rst_skid", 32'(in_ready), 32'd0);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      #1;
      check("mid_rst_valid", 32'(out_valid), 32'd0);
      check("mid_rst_rd", 32'(out_rd), 32'd0);
      issue(5'd8, 5'd0, 5'd1, 3'd5);
      #1 check("mid_rst_ready", 32'(in_ready), 32'd1);
      out_ready = 1'b1;
      tick(); idle();
      check("mid_rst_issue_valid", 32'(out_valid), 32'd1);
      check("mid_rst_issue_rd", 32'(out_rd), 32'd1);
      check("mid_rst_r8_cleared", out_a, 32'd0);
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
